// File: rtl/conv_pkg.sv
// Constants shared by the 3x3 window generator, CWODSP and the stages after it.
package conv_pkg;
  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int RESULT_W = 24;
endpackage

// File: rtl/line_buffer.sv
// Single-row pixel delay: a circular buffer with one shared read/write pointer.
// The read is asynchronous, so the storage can map onto distributed RAM.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Contents are never cleared; rows 0..1 of a frame refill them before any window is emitted.
  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

  // The slot about to be overwritten holds the pixel from exactly DEPTH accepts ago.
  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator for CWODSP. Optional per-frame window counter
// on port win_cnt is built only when the macro WIN_CNT_EN is defined.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic [PIX_W-1:0] f11,
  output logic [PIX_W-1:0] f12,
  output logic [PIX_W-1:0] f13,
  output logic [PIX_W-1:0] f21,
  output logic [PIX_W-1:0] f22,
  output logic [PIX_W-1:0] f23,
  output logic [PIX_W-1:0] f31,
  output logic [PIX_W-1:0] f32,
  output logic [PIX_W-1:0] f33,
  output logic             win_valid,
  output logic             frame_done
`ifdef WIN_CNT_EN
  ,
  output logic [15:0]      win_cnt
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WIN_TAPS-1:0][PIX_W-1:0] taps_q, taps_d;
  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;
  logic last_col, last_row;
  logic buf_en;
  logic [PIX_W-1:0] a_out, b_out;

  // Reset wins over a coincident pixel, so the buffers must not advance either.
  assign buf_en = pix_valid & ~reset;

  line_buffer #(.DEPTH(IMG_WIDTH)) u_buf_a (
    .clk   (clk),
    .reset (reset),
    .en    (buf_en),
    .din   (pix_in),
    .dout  (a_out)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_buf_b (
    .clk   (clk),
    .reset (reset),
    .en    (buf_en),
    .din   (a_out),
    .dout  (b_out)
  );

  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

  // Tap index 0 is f11, 8 is f33; each row shifts left and takes a new right column.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    taps_d       = taps_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      taps_d[0] = taps_q[1];
      taps_d[1] = taps_q[2];
      taps_d[2] = b_out;
      taps_d[3] = taps_q[4];
      taps_d[4] = taps_q[5];
      taps_d[5] = a_out;
      taps_d[6] = taps_q[7];
      taps_d[7] = taps_q[8];
      taps_d[8] = pix_in;
      win_valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
      frame_done_d = last_col && last_row;
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) row_d = last_row ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      taps_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      taps_q       <= taps_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign f11        = taps_q[0];
  assign f12        = taps_q[1];
  assign f13        = taps_q[2];
  assign f21        = taps_q[3];
  assign f22        = taps_q[4];
  assign f23        = taps_q[5];
  assign f31        = taps_q[6];
  assign f32        = taps_q[7];
  assign f33        = taps_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

`ifdef WIN_CNT_EN
  logic [15:0] win_cnt_q, win_cnt_d;

  // The frame_done cycle shows the final count; it clears on the cycle after.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (frame_done_q)
      win_cnt_d = '0;
    else if (win_valid_d && (win_cnt_q != 16'hFFFF))
      win_cnt_d = win_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) win_cnt_q <= '0;
    else       win_cnt_q <= win_cnt_d;
  end

  assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: directed ramps plus random frames
// compared against an image-array reference model.
module tb_conv_window_gen;
  localparam int W = 5;
  localparam int H = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_valid = 1'b0;
  logic [7:0] pix_in = 8'd0;
  logic [7:0] f11, f12, f13, f21, f22, f23, f31, f32, f33;
  logic win_valid, frame_done;
`ifdef WIN_CNT_EN
  logic [15:0] win_cnt;
`endif

  conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .f11        (f11),
    .f12        (f12),
    .f13        (f13),
    .f21        (f21),
    .f22        (f22),
    .f23        (f23),
    .f31        (f31),
    .f32        (f32),
    .f33        (f33),
    .win_valid  (win_valid),
    .frame_done (frame_done)
`ifdef WIN_CNT_EN
    ,
    .win_cnt    (win_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int img [H][W];
  int mr = 0, mc = 0;
  int strobes = 0;
  int mcnt = 0;
  int first_pix;
  logic prev_fd = 1'b0;
  logic last_strobe = 1'b0;
  logic got_first = 1'b0;
  logic [71:0] last_win = '0;
  logic [71:0] first_win_obs = '0;
  logic [71:0] taps_obs;

  assign taps_obs = {f11, f12, f13, f21, f22, f23, f31, f32, f33};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle (v=1 accepts d), then compare against the image model.
  task automatic step(input logic v, input logic [7:0] d);
    logic ewv, efd;
    logic [71:0] ewin;
    @(negedge clk);
    pix_valid = v;
    pix_in    = d;
    @(posedge clk);
    #1;
    ewv  = 1'b0;
    efd  = 1'b0;
    ewin = '0;
    if (v) begin
      img[mr][mc] = int'(d);
      ewv = (mr >= 2) && (mc >= 2);
      efd = (mr == H - 1) && (mc == W - 1);
      if (ewv)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ewin = {ewin[63:0], 8'(img[mr-2+i][mc-2+j])};
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    chk("win_valid", 72'(win_valid), 72'(ewv));
    chk("frame_done", 72'(frame_done), 72'(efd));
    if (ewv) begin
      chk("taps", taps_obs, ewin);
      last_win    = ewin;
      last_strobe = 1'b1;
      strobes++;
      if (!got_first) begin
        got_first     = 1'b1;
        first_win_obs = taps_obs;
      end
    end else if (!v && last_strobe) begin
      chk("taps_hold", taps_obs, last_win);
    end else if (v) begin
      last_strobe = 1'b0;
    end
    if (prev_fd) mcnt = 0;
    if (ewv && mcnt < 65535) mcnt++;
    prev_fd = efd;
`ifdef WIN_CNT_EN
    chk("win_cnt", 72'(win_cnt), 72'(mcnt));
`endif
  endtask

  // Reset with pix_valid high: the pixel must be discarded.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset     = 1'b1;
      pix_valid = 1'b1;
      pix_in    = 8'hEE;
      @(posedge clk);
      #1;
      mr = 0;
      mc = 0;
      mcnt = 0;
      prev_fd = 1'b0;
      last_strobe = 1'b0;
      chk("rst_win_valid", 72'(win_valid), 72'd0);
      chk("rst_frame_done", 72'(frame_done), 72'd0);
      chk("rst_taps", taps_obs, 72'd0);
`ifdef WIN_CNT_EN
      chk("rst_win_cnt", 72'(win_cnt), 72'd0);
`endif
    end
    @(negedge clk);
    reset     = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Continuous 5x5 ramp
    strobes = 0; got_first = 1'b0;
    for (int p = 0; p < 25; p++) step(1'b1, 8'(p));
    chk("ramp_strobes", 72'(strobes), 72'd9);
    chk("ramp_first", first_win_obs, 72'h00_01_02_05_06_07_0A_0B_0C);
    chk("ramp_last", {56'd0, taps_obs[71:64], taps_obs[7:0]}, {56'd0, 8'd12, 8'd24});

    // Same ramp with 3 idle cycles after every pixel
    strobes = 0; got_first = 1'b0;
    for (int p = 0; p < 25; p++) begin
      step(1'b1, 8'(p));
      repeat (3) step(1'b0, 8'hA5);
    end
    chk("gap_strobes", 72'(strobes), 72'd9);
    chk("gap_first", first_win_obs, 72'h00_01_02_05_06_07_0A_0B_0C);

    // Two back-to-back frames
    strobes = 0;
    for (int p = 0; p < 25; p++) step(1'b1, 8'(p));
    got_first = 1'b0;
    for (int p = 100; p < 125; p++) step(1'b1, 8'(p));
    chk("b2b_strobes", 72'(strobes), 72'd18);
    chk("b2b_first", {56'd0, first_win_obs[71:64], first_win_obs[7:0]}, {56'd0, 8'd100, 8'd112});

    // Random pixels with random idle gaps
    strobes = 0;
    for (int k = 0; k < 3 * W * H; k++) begin
      step(1'b1, 8'($urandom));
      if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
    end
    chk("rand_strobes", 72'(strobes), 72'd27);

    // Reset mid-frame after pixel 13, then a fresh frame 50..74
    for (int p = 0; p < 14; p++) step(1'b1, 8'(p));
    do_reset(1);
    strobes = 0; got_first = 1'b0; first_pix = -1;
    for (int p = 50; p < 75; p++) begin
      step(1'b1, 8'(p));
      if (got_first && first_pix < 0) first_pix = p;
    end
    chk("rst_first_pix", 72'(first_pix), 72'd62);
    chk("rst_first_win", {56'd0, first_win_obs[71:64], first_win_obs[7:0]}, {56'd0, 8'd50, 8'd62});
    chk("rst_strobes", 72'(strobes), 72'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator placed directly upstream of the CWODSP convolution stage. Accepts a raster-order 8-bit pixel stream, buffers the two previous image rows, and presents each complete 3x3 neighbourhood as nine 8-bit taps f11..f33. A one-cycle `win_valid` strobe drives CWODSP `start`. Only full windows are produced ("valid" convolution): (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.

## Interface
- IMG_WIDTH, 8, pixels per row; legal range 3..1024
- IMG_HEIGHT, 8, rows per frame; legal range 3..1024
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pix_in  in  8  pixel data; sampled when pix_valid=1
- pix_valid  in  1  pixel accepted on this edge; no backpressure, every valid pixel is consumed
- f11..f33  out  8 each  window taps; fRC = row R (1 = oldest), column C (1 = leftmost)
- win_valid  out  1  one-cycle strobe: taps hold a complete window
- frame_done  out  1  one-cycle strobe coincident with the last window of a frame
- win_cnt  out  16  windows emitted this frame (WIN_CNT_EN only)

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) track the position of the next accepted pixel.
- On each accepted pixel:
  - Two row-delay line buffers, each IMG_WIDTH deep, advance. Buffer A outputs pixel (row-1, col). Buffer B is fed by A and outputs pixel (row-2, col).
  - The 3x3 tap register shifts left one column. The new right column is f13 = B output, f23 = A output, f33 = pix_in.
  - col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At the last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1), both counters return to 0.
- A window is valid when the accepted pixel has row>=2 and col>=2. The register window crosses row boundaries unconditionally. Windows with col<2 would contain stale columns and are suppressed.
- With pix_valid=0, nothing changes: counters, buffers and taps hold, and win_valid=0.
- Taps hold their value between strobes. Downstream must sample on the win_valid cycle.
- Tap arithmetic: pure data movement, with no width change.
- Frames run back to back. The first pixel after the last pixel of a frame is (0,0) of the next frame, with no idle cycle required.

## Timing
- Reset values: f11..f33=0, win_valid=0, frame_done=0, win_cnt=0, col=0, row=0.
- Line-buffer contents are not cleared by reset. Stale data is never emitted because row<2 suppresses windows.
- Latency: the pixel accepted at edge N appears as f33, with win_valid=1, after edge N (registered output).
- Maximum throughput: one window per clock while pix_valid is held high within valid columns.
- frame_done=1 only in the same cycle as win_valid for window (row IMG_HEIGHT-1, col IMG_WIDTH-1).
- If reset coincides with pix_valid, reset wins: the pixel is discarded and the next pixel is (0,0).
- Reset mid-frame: the next accepted pixel starts a new frame. No window is emitted until two full rows are refilled.
- CWODSP pairing: win_valid -> start gives CWODSP done one cycle after win_valid.

## Configuration
- WIN_CNT_EN defined:
  - `win_cnt` port exists.
  - It increments by 1 on every win_valid and saturates at 16'hFFFF.
  - It clears to 0 on reset and on the cycle after frame_done.
  - On the frame_done cycle it shows the final count.
- WIN_CNT_EN undefined: `win_cnt` port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `conv_pkg`: PIX_W=8, WIN_TAPS=9, RESULT_W=24. These constants are shared with CWODSP and downstream stages.
- Sub-module `line_buffer`: a single-row delay of parameterised depth with enable (pix_valid) and 8-bit data. It is instantiated twice, chained A->B. Implementation is a circular buffer with a write/read pointer, inferable as distributed RAM.
- Top level holds the position counters, the 3x3 tap shift register, strobe logic, and the optional counter.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=5, pixels 0..24 continuous:
  - First win_valid occurs after pixel 12, with taps f11..f33 = 0,1,2,5,6,7,10,11,12.
  - Exactly 9 strobes occur. The last has f11=12, f33=24, with frame_done=1.
- Same stream with pix_valid deasserted for 3 cycles after every pixel: identical 9 windows in order, taps held during gaps, no extra strobes.
- Two back-to-back frames (values 0..24 then 100..124): the second frame's first window has f11=100, f33=112. No window mixes the two frames' rows 0..1.
- Reset asserted for 1 cycle after pixel 13 of a frame, then pixels 50..74 supplied:
  - win_valid stays 0 until pixel 62.
  - The window there has f11=50, f33=62.
- WIN_CNT_EN defined, 8x8 frame of value 7:
  - 36 strobes, each with all taps=7.
  - win_cnt=36 on the frame_done cycle, then 0 on the next cycle.
- Chain into CWODSP with all weights=1 and the 5x5 ramp: first CWODSP result is 54, and done is high one cycle after win_valid.
